// File: rtl/aes_mix_columns_seq.sv
// AES forward MixColumns, COLS_PER_CYCLE columns per clock; latency 4/COLS_PER_CYCLE cycles accept->outValid.
// Result held in DONE until outReady; inReady only in IDLE, so one state in flight at a time.
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inData,
  input  logic         inBypass,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic         byp_q, byp_d;
  logic         in_rdy_q, in_rdy_d;
  logic         out_vld_q, out_vld_d;
  logic [1:0]   col_idx;
  logic [31:0]  col_in;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] r0, r1, r2, r3;
    {b0, b1, b2, b3} = c;
    r0 = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
    r1 = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
    r2 = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
    r3 = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
    return {r0, r1, r2, r3};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    byp_d   = byp_q;
    col_idx = 2'd0;
    col_in  = 32'd0;
    case (state_q)
      IDLE: begin
        if (inValid && in_rdy_q) begin
          data_d  = inData;
          byp_d   = inBypass;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Column k lives at bit offset (3-k)*32, i.e. {~k, 5'b0}.
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          col_idx = cnt_q + 2'(g);
          col_in  = data_q[{~col_idx, 5'b00000} +: 32];
          data_d[{~col_idx, 5'b00000} +: 32] = byp_q ? col_in : mix_col(col_in);
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_rdy_d  = (state_d == IDLE);
    out_vld_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      data_q    <= 128'd0;
      byp_q     <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      byp_q     <= byp_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign inReady  = in_rdy_q;
  assign outValid = out_vld_q;
  assign outData  = data_q;

endmodule

// File: doc/aes_mix_columns_seq.md
Name: aes_mix_columns_seq

Overview:
- Forward AES MixColumns unit, the encrypt-direction counterpart of the existing combinational InvMixColumns function.
- Accepts one 128-bit AES state over a valid/ready handshake.
- Multiplies each 32-bit column by the circulant matrix {02,03,01,01} in GF(2^8), using the AES reduction polynomial 0x11B.
- Processes COLS_PER_CYCLE columns per clock and holds the result until the consumer accepts it.
- Sits in the XTS encrypt round datapath between ShiftRows and AddRoundKey.

Parameters:
- COLS_PER_CYCLE, 1, number of columns transformed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- inValid  input  1  input state valid
- inReady  output  1  block can accept a state
- inData  input  128  AES state. Column 0 = [127:96], column 3 = [31:0]. Byte 0 of each column is the column's MSB byte.
- inBypass  input  1  captured with inData. When 1, the state passes through unchanged (final round).
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- outData  output  128  transformed state, same layout as inData

Behaviour:
- Reset values (any cycle rst=1): inReady=0, outValid=0, outData=0, column counter=0, FSM=IDLE.
  - rst mid-operation aborts the block in flight with no output.
  - inReady goes to 1 on the first cycle after rst deasserts.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - inReady=1, outValid=0.
  - On inValid=1: capture inData into the working register, capture inBypass, clear the column counter, go to CALC.
- CALC:
  - inReady=0, outValid=0.
  - Each clock, columns counter..counter+COLS_PER_CYCLE-1 of the working register are replaced by their MixColumns result, or left unchanged if bypass was captured.
  - The counter advances by COLS_PER_CYCLE.
  - After the clock that processes column 3, go to DONE.
  - CALC lasts N = 4/COLS_PER_CYCLE cycles.
- DONE:
  - outValid=1, and outData drives the working register.
  - outData stays stable while outValid=1 and outReady=0.
  - On outReady=1: go to IDLE.
- Latency:
  - Accept edge at T; outValid is first high in the cycle after edge T+N.
  - Bypass uses the same latency, so round timing stays uniform.
- Throughput: one state per N+2 cycles minimum. inReady is never high in the same cycle as outValid, so no simultaneous in/out handshake exists.
- Per column (b0..b3 → r0..r3), with xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00):
  - r0 = xt(b0)^xt(b1)^b1^b2^b3
  - r1 = b0^xt(b1)^xt(b2)^b2^b3
  - r2 = b0^b1^xt(b2)^xt(b3)^b3
  - r3 = xt(b0)^b0^b1^b2^xt(b3)
- Arithmetic is 8-bit GF(2^8) with no carries. Column datapath logic is instantiated COLS_PER_CYCLE times and muxed by the counter.
- Inputs are ignored outside IDLE:
  - inValid, inData and inBypass have no effect in CALC or DONE.
  - inData does not need to stay stable after the accept edge.
- outReady is ignored outside DONE.
- The counter wraps only via the CALC→DONE transition and never exceeds 3.

Test Plan:
1. FIPS-197 vector, COLS_PER_CYCLE=1. inData=db135345_f20a225c_01010101_c6c6c6c6, inBypass=0 → outData=8e4da1bc_9fdc589d_01010101_c6c6c6c6. outValid is first high 4 cycles after the accept edge; inReady=0 throughout CALC/DONE.
2. Vector d4d4d4d5_2d26314c_00000000_ffffffff, run with COLS_PER_CYCLE=1, 2 and 4 → outData=d5d5d7d6_4d7ebdf8_00000000_ffffffff in all cases. Latency is 4, 2 and 1 cycles respectively.
3. Bypass: inData=00112233_44556677_8899aabb_ccddeeff, inBypass=1 → outData is identical to the input, with the same latency as the non-bypass case.
4. Back-pressure: hold outReady=0 for 10 cycles after outValid rises.
   - outValid=1 and outData stay stable throughout.
   - inReady=0, and a second inValid pulse is ignored.
   - Release outReady → IDLE on the next cycle; inReady=1.
5. Reset mid-CALC: assert rst on the 2nd CALC cycle.
   - The next cycle shows outValid=0, outData=0, inReady=0.
   - After deassert, a fresh vector-1 transaction produces the correct result with no residue.
6. Back-to-back stream: 16 random states with random inValid/outReady gaps. Every output matches the golden model (MixColumns as defined above), in order, with no drops or duplicates.
